// File: rtl/alu_ctrl_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer_pkg
//   Shared definitions for the ALU-control sequencer. It holds the ALUControl
//   operation codes (5-bit base encoding, zero-extended by the top to CTRL_W),
//   the R-type funct field values, the ALUOp classes, the mult/div op codes,
//   the FSM states, the decoder result struct and a small max helper.
// -----------------------------------------------------------------------------
package alu_ctrl_sequencer_pkg;

    typedef logic [4:0] code_t;

    // ALUControl operation codes
    localparam code_t ALU_SLL   = 5'd0;
    localparam code_t ALU_SRL   = 5'd1;
    localparam code_t ALU_SRA   = 5'd2;
    localparam code_t ALU_SLLV  = 5'd3;
    localparam code_t ALU_SRLV  = 5'd4;
    localparam code_t ALU_SRAV  = 5'd5;
    localparam code_t ALU_ADD   = 5'd6;
    localparam code_t ALU_SUB   = 5'd7;
    localparam code_t ALU_AND   = 5'd8;
    localparam code_t ALU_OR    = 5'd9;
    localparam code_t ALU_XOR   = 5'd10;
    localparam code_t ALU_NOR   = 5'd11;
    localparam code_t ALU_SLT   = 5'd12;
    localparam code_t ALU_MULT  = 5'd13;
    localparam code_t ALU_MULTU = 5'd14;
    localparam code_t ALU_DIV   = 5'd15;
    localparam code_t ALU_DIVU  = 5'd16;
    localparam code_t ALU_MFHI  = 5'd17;
    localparam code_t ALU_MFLO  = 5'd18;

    // R-type funct field values
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    // ALUOp classes from the main decoder (11 is a legacy alias of subtract)
    typedef enum logic [1:0] {
        ALUOP_ADD     = 2'b00,
        ALUOP_SUB     = 2'b01,
        ALUOP_RTYPE   = 2'b10,
        ALUOP_SUB_ALT = 2'b11
    } aluop_e;

    // Mult/div op codes; bit 1 set means a divide
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MD_RUN  = 2'b01,
        ST_MD_DONE = 2'b10
    } state_e;

    typedef struct packed {
        code_t  code;
        logic   is_md;
        md_op_e md_op;
        logic   illegal;
    } decode_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer_if
//   Bundles the sequencer's instruction handshake and control outputs.
//   master : the upstream main decoder / HI-LO side (drives in_valid, funct, ALUOp)
//   slave  : the sequencer (drives in_ready, ALUControl, ctrl_valid, illegal,
//            md_start, md_op, hilo_we)
// -----------------------------------------------------------------------------
interface alu_ctrl_sequencer_if #(
    parameter int CTRL_W = 5
) ();

    logic              in_valid;
    logic              in_ready;
    logic [5:0]        funct;
    logic [1:0]        ALUOp;
    logic [CTRL_W-1:0] ALUControl;
    logic              ctrl_valid;
    logic              illegal;
    logic              md_start;
    logic [1:0]        md_op;
    logic              hilo_we;

    modport master (
        output in_valid, funct, ALUOp,
        input  in_ready, ALUControl, ctrl_valid, illegal, md_start, md_op, hilo_we
    );

    modport slave (
        input  in_valid, funct, ALUOp,
        output in_ready, ALUControl, ctrl_valid, illegal, md_start, md_op, hilo_we
    );

endinterface

// File: rtl/alu_ctrl_sequencer_funct_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer_funct_decode
//   Pure combinational decode of {ALUOp, funct} into the base ALUControl code,
//   a mult/div flag with its op code, and an illegal-funct flag.
//   Ports:
//     alu_op  in   2   ALUOp class from the main decoder
//     funct   in   6   R-type funct field
//     dec     out  decode_t {code, is_md, md_op, illegal}
// -----------------------------------------------------------------------------
module alu_ctrl_sequencer_funct_decode
    import alu_ctrl_sequencer_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path can
        // leave a field unassigned and infer a latch.
        dec.code    = ALU_ADD;
        dec.is_md   = 1'b0;
        dec.md_op   = MD_MULT;
        dec.illegal = 1'b0;

        case (aluop_e'(alu_op))
            ALUOP_ADD:                dec.code = ALU_ADD;
            ALUOP_SUB, ALUOP_SUB_ALT: dec.code = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F_SLL:   dec.code = ALU_SLL;
                    F_SRL:   dec.code = ALU_SRL;
                    F_SRA:   dec.code = ALU_SRA;
                    F_SLLV:  dec.code = ALU_SLLV;
                    F_SRLV:  dec.code = ALU_SRLV;
                    F_SRAV:  dec.code = ALU_SRAV;
                    F_ADD:   dec.code = ALU_ADD;
                    F_SUB:   dec.code = ALU_SUB;
                    F_AND:   dec.code = ALU_AND;
                    F_OR:    dec.code = ALU_OR;
                    F_XOR:   dec.code = ALU_XOR;
                    F_NOR:   dec.code = ALU_NOR;
                    F_SLT:   dec.code = ALU_SLT;
                    F_MFHI:  dec.code = ALU_MFHI;
                    F_MFLO:  dec.code = ALU_MFLO;
                    F_MULT: begin
                        dec.code  = ALU_MULT;
                        dec.is_md = 1'b1;
                        dec.md_op = MD_MULT;
                    end
                    F_MULTU: begin
                        dec.code  = ALU_MULTU;
                        dec.is_md = 1'b1;
                        dec.md_op = MD_MULTU;
                    end
                    F_DIV: begin
                        dec.code  = ALU_DIV;
                        dec.is_md = 1'b1;
                        dec.md_op = MD_DIV;
                    end
                    F_DIVU: begin
                        dec.code  = ALU_DIVU;
                        dec.is_md = 1'b1;
                        dec.md_op = MD_DIVU;
                    end
                    // Unknown funct falls back to a harmless ADD and is flagged
                    default: dec.illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer
//   Registers the decoded ALUControl word for each accepted instruction and
//   sequences multi-cycle mult/div ops. While a mult/div runs, in_ready is low
//   and the upstream holds its next instruction. When the op ends, hilo_we
//   pulses and the next instruction (including MFHI/MFLO) may be accepted.
//   Parameters:
//     CTRL_W      ALUControl width (>= 5)
//     MUL_CYCLES  cycles spent running MULT/MULTU (>= 1)
//     DIV_CYCLES  cycles spent running DIV/DIVU (>= 1)
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of alu_ctrl_sequencer_if
// -----------------------------------------------------------------------------
module alu_ctrl_sequencer
    import alu_ctrl_sequencer_pkg::*;
#(
    parameter int CTRL_W     = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_ctrl_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    // The counter is loaded with N-1, so the FSM stays in MD_RUN for exactly N cycles
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    generate
        if (CTRL_W < 5) begin : g_bad_ctrl_w
            $error("alu_ctrl_sequencer: CTRL_W must be >= 5");
        end
        if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cycles
            $error("alu_ctrl_sequencer: MUL_CYCLES and DIV_CYCLES must be >= 1");
        end
    endgenerate

    decode_t           dec;
    logic              accept;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] alu_control_q;
    logic              ctrl_valid_q;
    logic              illegal_q;
    logic              md_start_q;
    md_op_e            md_op_q;
    logic              hilo_we_q;

    alu_ctrl_sequencer_funct_decode u_decode (
        .alu_op (bus.ALUOp),
        .funct  (bus.funct),
        .dec    (dec)
    );

    assign bus.in_ready = (state_q != ST_MD_RUN);
    assign accept       = bus.in_valid & bus.in_ready;

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_MD_DONE: begin
                if (accept && dec.is_md) begin
                    state_d = ST_MD_RUN;
                    cnt_d   = dec.md_op[1] ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MD_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_MD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output registers; ALUControl, illegal and md_op hold between accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control_q <= CTRL_W'(ALU_ADD);
            ctrl_valid_q  <= 1'b0;
            illegal_q     <= 1'b0;
            md_start_q    <= 1'b0;
            md_op_q       <= MD_MULT;
            hilo_we_q     <= 1'b0;
        end else begin
            ctrl_valid_q <= accept;
            md_start_q   <= accept & dec.is_md;
            // Last MD_RUN cycle: the pulse lands exactly in the MD_DONE cycle
            hilo_we_q    <= (state_q == ST_MD_RUN) && (cnt_q == '0);
            if (accept) begin
                alu_control_q <= CTRL_W'(dec.code);
                illegal_q     <= dec.illegal;
                if (dec.is_md) begin
                    md_op_q <= dec.md_op;
                end
            end
        end
    end

    assign bus.ALUControl = alu_control_q;
    assign bus.ctrl_valid = ctrl_valid_q;
    assign bus.illegal    = illegal_q;
    assign bus.md_start   = md_start_q;
    assign bus.md_op      = md_op_q;
    assign bus.hilo_we    = hilo_we_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_sequencer
//   Directed bench for alu_ctrl_sequencer (CTRL_W=5, MUL_CYCLES=4, DIV_CYCLES=32).
//   Inputs change 1 time unit after a rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_ctrl_sequencer_if #(.CTRL_W(5)) bus ();

    alu_ctrl_sequencer #(
        .CTRL_W     (5),
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f);
        bus.in_valid = v;
        bus.ALUOp    = op;
        bus.funct    = f;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] f;
        int         code;
        int         ill;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{2'b10, 6'h24,  8, 0};  // AND
        vecs[1]  = '{2'b11, 6'h3F,  7, 0};  // legacy sub alias, funct ignored
        vecs[2]  = '{2'b00, 6'h2A,  6, 0};  // add, funct ignored
        vecs[3]  = '{2'b01, 6'h00,  7, 0};  // sub
        vecs[4]  = '{2'b10, 6'h3F,  6, 1};  // illegal funct
        vecs[5]  = '{2'b10, 6'h00,  0, 0};  // SLL
        vecs[6]  = '{2'b10, 6'h03,  2, 0};  // SRA
        vecs[7]  = '{2'b10, 6'h2A, 12, 0};  // SLT
        vecs[8]  = '{2'b10, 6'h10, 17, 0};  // MFHI
        vecs[9]  = '{2'b10, 6'h27, 11, 0};  // NOR
        vecs[10] = '{2'b10, 6'h05,  6, 1};  // hole in the table -> illegal
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic saw_we;

        rst_n = 1'b0;
        drive(1'b0, 2'b00, 6'h00);
        #12;
        check("rst ALUControl", 32'(bus.ALUControl), 6);
        check("rst ctrl_valid", 32'(bus.ctrl_valid), 0);
        check("rst illegal",    32'(bus.illegal),    0);
        check("rst md_start",   32'(bus.md_start),   0);
        check("rst md_op",      32'(bus.md_op),      0);
        check("rst hilo_we",    32'(bus.hilo_we),    0);
        check("rst in_ready",   32'(bus.in_ready),   1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single-cycle decodes, one accept per cycle
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].f);
            step();
            check($sformatf("vec%0d ALUControl", i), 32'(bus.ALUControl), vecs[i].code);
            check($sformatf("vec%0d illegal", i),    32'(bus.illegal),    vecs[i].ill);
            check($sformatf("vec%0d ctrl_valid", i), 32'(bus.ctrl_valid), 1);
            check($sformatf("vec%0d md_start", i),   32'(bus.md_start),   0);
            check($sformatf("vec%0d in_ready", i),   32'(bus.in_ready),   1);
        end

        // No accept: outputs hold, ctrl_valid drops
        drive(1'b0, 2'b10, 6'h24);
        step();
        check("hold ctrl_valid", 32'(bus.ctrl_valid), 0);
        check("hold ALUControl", 32'(bus.ALUControl), 6);
        check("hold illegal",    32'(bus.illegal),    1);

        // MULT: 4 cycles with in_ready low, hilo_we in the 5th
        drive(1'b1, 2'b10, 6'h18);
        step();
        drive(1'b0, 2'b00, 6'h00);
        check("mult ALUControl", 32'(bus.ALUControl), 13);
        check("mult md_op",      32'(bus.md_op),      0);
        check("mult illegal",    32'(bus.illegal),    0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mult run%0d in_ready", i), 32'(bus.in_ready), 0);
            check($sformatf("mult run%0d md_start", i), 32'(bus.md_start), (i == 0) ? 1 : 0);
            check($sformatf("mult run%0d hilo_we", i),  32'(bus.hilo_we),  0);
            step();
        end
        check("mult done hilo_we",  32'(bus.hilo_we),  1);
        check("mult done in_ready", 32'(bus.in_ready), 1);
        step();
        check("mult idle hilo_we",  32'(bus.hilo_we),  0);
        check("mult idle in_ready", 32'(bus.in_ready), 1);

        // DIVU then MFLO held on in_valid: MFLO accepted in the MD_DONE cycle
        drive(1'b1, 2'b10, 6'h1B);
        step();
        drive(1'b1, 2'b10, 6'h12);
        check("divu ALUControl", 32'(bus.ALUControl), 16);
        check("divu md_op",      32'(bus.md_op),      3);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("divu run%0d in_ready", i),   32'(bus.in_ready),   0);
            check($sformatf("divu run%0d ctrl_valid", i), 32'(bus.ctrl_valid), (i == 0) ? 1 : 0);
            check($sformatf("divu run%0d ALUControl", i), 32'(bus.ALUControl), 16);
            step();
        end
        check("divu done hilo_we",  32'(bus.hilo_we),  1);
        check("divu done in_ready", 32'(bus.in_ready), 1);
        step();
        drive(1'b0, 2'b00, 6'h00);
        check("mflo ALUControl", 32'(bus.ALUControl), 18);
        check("mflo ctrl_valid", 32'(bus.ctrl_valid), 1);
        check("mflo md_start",   32'(bus.md_start),   0);
        check("mflo hilo_we",    32'(bus.hilo_we),    0);
        check("mflo md_op held", 32'(bus.md_op),      3);
        check("mflo in_ready",   32'(bus.in_ready),   1);

        // Reset two cycles into a DIV aborts it without any hilo_we
        drive(1'b1, 2'b10, 6'h1A);
        step();
        drive(1'b0, 2'b00, 6'h00);
        check("div md_op", 32'(bus.md_op), 2);
        step();
        check("div run in_ready", 32'(bus.in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("abort in_ready",   32'(bus.in_ready),   1);
        check("abort ALUControl", 32'(bus.ALUControl), 6);
        check("abort md_op",      32'(bus.md_op),      0);
        check("abort md_start",   32'(bus.md_start),   0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        saw_we = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.hilo_we !== 1'b0) saw_we = 1'b1;
        end
        check("abort no hilo_we", 32'(saw_we), 0);
        check("abort idle in_ready", 32'(bus.in_ready), 1);

        // MULTU then back-to-back MULT accepted in MD_DONE
        drive(1'b1, 2'b10, 6'h19);
        step();
        drive(1'b1, 2'b10, 6'h18);
        check("multu md_op", 32'(bus.md_op), 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("multu run%0d in_ready", i), 32'(bus.in_ready), 0);
            check($sformatf("multu run%0d md_start", i), 32'(bus.md_start), (i == 0) ? 1 : 0);
            step();
        end
        check("multu done hilo_we",  32'(bus.hilo_we),  1);
        check("multu done in_ready", 32'(bus.in_ready), 1);
        step();
        drive(1'b0, 2'b00, 6'h00);
        check("b2b md_start",   32'(bus.md_start),   1);
        check("b2b md_op",      32'(bus.md_op),      0);
        check("b2b ALUControl", 32'(bus.ALUControl), 13);
        check("b2b hilo_we",    32'(bus.hilo_we),    0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b run%0d in_ready", i), 32'(bus.in_ready), 0);
            step();
        end
        check("b2b done hilo_we",  32'(bus.hilo_we),  1);
        check("b2b done in_ready", 32'(bus.in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
